tcdm_dma_bank_mux: RTL
======================

Name: tcdm_dma_bank_mux

Overview:
- Per-bank 2:1 request mux between a core TCDM port and a DMA port, placed directly upstream of the bank's AMO shim.
- DMA has priority by default; a stall counter guarantees core forward progress.
- Drives the shim's DMA-access flag and routes read responses back to the correct requester with a valid strobe.
- Tracks core AMOs whose response is delayed by a DMA write burst until the shim replays it.

Parameters:
AddrMemWidth, 10, bank word-address width
DataWidth, 32, data width (32 or 64)
MaxStall, 15, consecutive denied core-request cycles before the core is forced through (1..255)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
core_req_i  in  1  core request
core_gnt_o  out  1  core grant
core_add_i  in  AddrMemWidth  core address
core_amo_i  in  4  core AMO opcode (0 = none)
core_wen_i  in  1  1 store / 0 load
core_wdata_i  in  DataWidth  core write data
core_be_i  in  DataWidth/8  core byte enable
core_rdata_o  out  DataWidth  core read data
core_rvalid_o  out  1  core response valid
dma_req_i  in  1  DMA request
dma_gnt_o  out  1  DMA grant
dma_add_i  in  AddrMemWidth  DMA address
dma_wen_i  in  1  DMA store/load
dma_wdata_i  in  DataWidth  DMA write data
dma_be_i  in  DataWidth/8  DMA byte enable
dma_rdata_o  out  DataWidth  DMA read data
dma_rvalid_o  out  1  DMA response valid
bank_req_o  out  1  request to shim
bank_gnt_i  in  1  shim grant
bank_add_o  out  AddrMemWidth  address to shim
bank_amo_o  out  4  opcode to shim (forced 0 for DMA)
bank_wen_o  out  1  store/load to shim
bank_wdata_o  out  DataWidth  write data to shim
bank_be_o  out  DataWidth/8  byte enable to shim
bank_rdata_i  in  DataWidth  read data from shim
dma_access_o  out  1  current bank cycle belongs to DMA

Behaviour:
- Reset (rst_ni low at a clock edge): all grants, rvalids and dma_access_o are 0; stall counter 0; state Idle; rdata outputs 0.
- Arbitration is combinational within the cycle. Winner = DMA if dma_req_i, unless (core_req_i and stall counter == MaxStall) or DMA is blocked (see AmoPend). Otherwise the core wins if core_req_i.
- Winner's fields go to the bank. dma_access_o = 1 iff the DMA is the selected winner. bank_amo_o = 0 whenever the DMA is selected.
- Grants: winner_gnt_o = bank_gnt_i; the loser's grant is 0.
- Stall counter: increments (saturating at MaxStall) each cycle core_req_i is high without core_gnt_o; clears on core grant or when core_req_i is low.
- Non-AMO response: read or write granted in cycle t -> requester's rvalid = 1 at t+1, and rdata = bank_rdata_i for that requester. Writes also pulse rvalid.
- States:
  - Idle: normal operation. A core grant with core_amo_i != 0 -> AmoPend.
  - AmoPend: core AMO issued; response not yet delivered.
    - core_gnt_o forced 0.
    - DMA reads blocked (dma_gnt_o = 0, and they do not win).
    - DMA writes may still be granted.
    - Each cycle: if dma_access_o is 0, assert core_rvalid_o with core_rdata_o = bank_rdata_i, then -> Idle. Otherwise stay (the shim is prolonging the AMO).
- Simultaneous events:
  - A DMA write response at t+1 coinciding with the AMO replay cycle is legal: DMA write rvalid carries no meaningful data, and both rvalids may be high in the same cycle.
  - A core request and a DMA request in the same cycle with counter < MaxStall: DMA wins and the counter increments.
- Reset mid-AmoPend: returns to Idle; the pending core response is dropped with no rvalid.

Test Plan:
- Core load to addr 0x10 alone -> bank_req_o=1, dma_access_o=0, core_gnt_o=1 at t; core_rvalid_o=1 at t+1 with bank data 0xDEADBEEF.
- Core and DMA both request every cycle, MaxStall=3 -> DMA granted for 3 cycles, core granted on the 4th, counter back to 0.
- Core AMOAdd granted at t, no DMA -> core_rvalid_o=1 at t+1 with the old memory value; state back to Idle.
- Core AMO at t, DMA writes held for t+1..t+4 -> dma_gnt_o=1 and dma_access_o=1 for those cycles, core_rvalid_o=0; core_rvalid_o=1 at t+5 with the replayed old value.
- Core AMO pending while the DMA requests a read -> dma_gnt_o=0 until the core response is delivered; DMA read granted the following cycle, DMA rvalid one cycle later.
- Reset asserted during AmoPend -> next cycle all outputs 0, no core_rvalid_o, new core request accepted after release.

Source files
------------

// File: rtl/tcdm_dma_bank_mux_if.sv
// Bus bundle for the per-bank core/DMA request mux: core port, DMA port and shim-side port.
interface tcdm_dma_bank_mux_if #(
   parameter int unsigned AddrMemWidth = 10,
   parameter int unsigned DataWidth    = 32
);
   localparam int unsigned BeWidth = DataWidth / 8;

   logic                    core_req;
   logic                    core_gnt;
   logic [AddrMemWidth-1:0] core_add;
   logic [3:0]              core_amo;
   logic                    core_wen;
   logic [DataWidth-1:0]    core_wdata;
   logic [BeWidth-1:0]      core_be;
   logic [DataWidth-1:0]    core_rdata;
   logic                    core_rvalid;

   logic                    dma_req;
   logic                    dma_gnt;
   logic [AddrMemWidth-1:0] dma_add;
   logic                    dma_wen;
   logic [DataWidth-1:0]    dma_wdata;
   logic [BeWidth-1:0]      dma_be;
   logic [DataWidth-1:0]    dma_rdata;
   logic                    dma_rvalid;

   logic                    bank_req;
   logic                    bank_gnt;
   logic [AddrMemWidth-1:0] bank_add;
   logic [3:0]              bank_amo;
   logic                    bank_wen;
   logic [DataWidth-1:0]    bank_wdata;
   logic [BeWidth-1:0]      bank_be;
   logic [DataWidth-1:0]    bank_rdata;
   logic                    dma_access;

   // Environment view: drives core/DMA requests and the shim's grant/read data.
   modport master (
      output core_req, core_add, core_amo, core_wen, core_wdata, core_be,
      input  core_gnt, core_rdata, core_rvalid,
      output dma_req, dma_add, dma_wen, dma_wdata, dma_be,
      input  dma_gnt, dma_rdata, dma_rvalid,
      input  bank_req, bank_add, bank_amo, bank_wen, bank_wdata, bank_be, dma_access,
      output bank_gnt, bank_rdata
   );

   // Mux view.
   modport slave (
      input  core_req, core_add, core_amo, core_wen, core_wdata, core_be,
      output core_gnt, core_rdata, core_rvalid,
      input  dma_req, dma_add, dma_wen, dma_wdata, dma_be,
      output dma_gnt, dma_rdata, dma_rvalid,
      output bank_req, bank_add, bank_amo, bank_wen, bank_wdata, bank_be, dma_access,
      input  bank_gnt, bank_rdata
   );
endinterface

// File: rtl/tcdm_dma_bank_mux.sv
// Per-bank 2:1 core/DMA request mux in front of the AMO shim; DMA-priority with
// a core anti-starvation counter and tracking of core AMOs delayed by DMA writes.
module tcdm_dma_bank_mux #(
   parameter int unsigned AddrMemWidth = 10,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned MaxStall     = 15
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   tcdm_dma_bank_mux_if.slave   bus
);
   localparam int unsigned BeWidth  = DataWidth / 8;
   localparam int unsigned CntWidth = 8;

   typedef enum logic {Idle, AmoPend} state_e;

   state_e                  state;
   logic [CntWidth-1:0]     stall_cnt;
   logic                    core_rv_q;
   logic                    dma_rv_q;

   logic                    core_ok;
   logic                    dma_ok;
   logic                    sel_core;
   logic                    sel_dma;
   logic                    replay;
   logic [AddrMemWidth-1:0] add_sel;
   logic [DataWidth-1:0]    wdata_sel;
   logic [BeWidth-1:0]      be_sel;

   // Arbitration: DMA first unless the core has starved or DMA reads are held off by a pending AMO.
   always_comb begin
      core_ok  = 1'b0;
      dma_ok   = 1'b0;
      sel_core = 1'b0;
      sel_dma  = 1'b0;
      replay   = 1'b0;
      if (rst_ni) begin
         core_ok  = bus.core_req && (state == Idle);
         dma_ok   = bus.dma_req && ((state == Idle) || bus.dma_wen);
         sel_dma  = dma_ok && !(core_ok && (stall_cnt == CntWidth'(MaxStall)));
         sel_core = core_ok && !sel_dma;
         replay   = (state == AmoPend) && !sel_dma;
      end
   end

   always_comb begin
      add_sel   = bus.core_add;
      wdata_sel = bus.core_wdata;
      be_sel    = bus.core_be;
      if (sel_dma) begin
         add_sel   = bus.dma_add;
         wdata_sel = bus.dma_wdata;
         be_sel    = bus.dma_be;
      end
   end

   always_comb begin
      bus.bank_req    = sel_core || sel_dma;
      bus.bank_add    = add_sel;
      bus.bank_amo    = sel_dma ? 4'h0 : bus.core_amo;
      bus.bank_wen    = sel_dma ? bus.dma_wen : bus.core_wen;
      bus.bank_wdata  = wdata_sel;
      bus.bank_be     = be_sel;
      bus.dma_access  = sel_dma;
      bus.core_gnt    = sel_core && bus.bank_gnt;
      bus.dma_gnt     = sel_dma && bus.bank_gnt;
      // The replayed AMO result shares the response path with plain core responses.
      bus.core_rvalid = rst_ni && (core_rv_q || replay);
      bus.dma_rvalid  = rst_ni && dma_rv_q;
      bus.core_rdata  = bus.core_rvalid ? bus.bank_rdata : '0;
      bus.dma_rdata   = bus.dma_rvalid ? bus.bank_rdata : '0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state     <= Idle;
         stall_cnt <= '0;
         core_rv_q <= 1'b0;
         dma_rv_q  <= 1'b0;
      end else begin
         core_rv_q <= bus.core_gnt && (bus.core_amo == 4'h0);
         dma_rv_q  <= bus.dma_gnt;

         if (!bus.core_req || bus.core_gnt)
            stall_cnt <= '0;
         else if (stall_cnt < CntWidth'(MaxStall))
            stall_cnt <= stall_cnt + CntWidth'(1);

         case (state)
            Idle:    if (bus.core_gnt && (bus.core_amo != 4'h0)) state <= AmoPend;
            AmoPend: if (replay) state <= Idle;
            default: state <= Idle;
         endcase
      end
   end
endmodule
